// File: rtl/control_fsm_pkg.sv
// Shared types and encodings for the 16-bit processor control unit:
// FSM states, instruction classes, opcode/ext fields and ALU operation codes.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_SHIFT,
        S_WB,
        S_MEMRD,
        S_LDWB,
        S_MEMWR
    } state_e;

    typedef enum logic [2:0] {
        ALU_R,
        ALU_I,
        SHIFT,
        LOAD,
        STOR,
        ILLEGAL
    } class_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_MEM   = 4'b0100;

    // ALU selectors: the R-type ext code and the I-type op share these values
    localparam logic [3:0] SEL_AND = 4'b0001;
    localparam logic [3:0] SEL_OR  = 4'b0010;
    localparam logic [3:0] SEL_XOR = 4'b0011;
    localparam logic [3:0] SEL_ADD = 4'b0101;
    localparam logic [3:0] SEL_SUB = 4'b1001;
    localparam logic [3:0] SEL_CMP = 4'b1011;
    localparam logic [3:0] SEL_MOV = 4'b1101;

    localparam logic [3:0] EXT_LSH  = 4'b0100;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b0101;
    localparam logic [3:0] ALU_MOV = 4'b0110;

    localparam logic [1:0] MUX4_SRC  = 2'b00;
    localparam logic [1:0] MUX4_SIGN = 2'b01;
    localparam logic [1:0] REGPC_SRC = 2'b00;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       pc_reg_en;
        logic       src_reg_en;
        logic       dst_reg_en;
        logic       imm_reg_en;
        logic       result_reg_en;
        logic       sign_en;
        logic       reg_file_en;
        logic       pc_reg_mux_en;
        logic       shift_alu_mux_en;
        logic       reg_imm_mux_en;
        logic       ex_mem_result_en;
        logic       ir_s;
        logic [1:0] mux4_en;
        logic [1:0] regpc_cont;
        logic       mem_read;
        logic       mem_write;
        logic       inst_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_alu_sel(input logic [3:0] sel);
        case (sel)
            SEL_AND, SEL_OR, SEL_XOR, SEL_ADD,
            SEL_SUB, SEL_CMP, SEL_MOV: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] sel);
        case (sel)
            SEL_AND: return ALU_AND;
            SEL_OR:  return ALU_OR;
            SEL_XOR: return ALU_XOR;
            SEL_SUB: return ALU_SUB;
            SEL_CMP: return ALU_CMP;
            SEL_MOV: return ALU_MOV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction input and datapath control bundle between the control unit
// (master) and the datapath it steers (slave).
interface control_fsm_if;
    logic [15:0] instruction;
    logic [3:0]  aluControl;
    logic        pcRegEn;
    logic        srcRegEn;
    logic        dstRegEn;
    logic        immRegEn;
    logic        resultRegEn;
    logic        signEn;
    logic        regFileEn;
    logic        pcRegMuxEn;
    logic        shiftALUMuxEn;
    logic        regImmMuxEn;
    logic        exMemResultEn;
    logic        irS;
    logic [1:0]  mux4En;
    logic [1:0]  regpcCont;
    logic        memRead;
    logic        memWrite;
    logic        instDone;
    logic        illegal;

    modport master (
        input  instruction,
        output aluControl, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn,
               signEn, regFileEn, pcRegMuxEn, shiftALUMuxEn, regImmMuxEn,
               exMemResultEn, irS, mux4En, regpcCont, memRead, memWrite,
               instDone, illegal
    );

    modport slave (
        output instruction,
        input  aluControl, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn,
               signEn, regFileEn, pcRegMuxEn, shiftALUMuxEn, regImmMuxEn,
               exMemResultEn, irS, mux4En, regpcCont, memRead, memWrite,
               instDone, illegal
    );
endinterface

// File: rtl/control_fsm_inst_decode.sv
// Classifies the latched op/ext fields into an instruction class and derives
// the ALU operation, immediate-operand and compare flags.
module inst_decode
    import proc_ctrl_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic [3:0] i_ext,
    output class_e     o_class,
    output logic [3:0] o_alu_control,
    output logic       o_is_imm,
    output logic       o_is_cmp
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        o_class       = ILLEGAL;
        o_alu_control = ALU_ADD;
        o_is_imm      = 1'b0;
        o_is_cmp      = 1'b0;

        if (i_op == OP_RTYPE) begin
            if (is_alu_sel(i_ext)) begin
                o_class       = ALU_R;
                o_alu_control = alu_code(i_ext);
                o_is_cmp      = (i_ext == SEL_CMP);
            end
        end else if (is_alu_sel(i_op)) begin
            o_class       = ALU_I;
            o_alu_control = alu_code(i_op);
            o_is_imm      = 1'b1;
            o_is_cmp      = (i_op == SEL_CMP);
        end else if (i_op == OP_SHIFT) begin
            if (i_ext == EXT_LSH) begin
                o_class = SHIFT;
            end else if (i_ext[3:1] == 3'b000) begin
                o_class  = SHIFT;
                o_is_imm = 1'b1;
            end
        end else if (i_op == OP_MEM) begin
            if (i_ext == EXT_LOAD) begin
                o_class = LOAD;
            end else if (i_ext == EXT_STOR) begin
                o_class = STOR;
            end
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle Moore control unit: latches op/ext at the end of FETCH and
// steps FETCH/DECODE/EXEC|SHIFT|MEMRD|MEMWR/WB|LDWB, driving the datapath.
module control_fsm
    import proc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.master bus
);

    state_e     r_state;
    logic [3:0] r_op;
    logic [3:0] r_ext;

    class_e     w_class;
    logic [3:0] w_alu_control;
    logic       w_is_imm;
    logic       w_is_cmp;
    ctrl_t      w_ctrl;

    inst_decode u_inst_decode (
        .i_op          (r_op),
        .i_ext         (r_ext),
        .o_class       (w_class),
        .o_alu_control (w_alu_control),
        .o_is_imm      (w_is_imm),
        .o_is_cmp      (w_is_cmp)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_op    <= 4'b0000;
            r_ext   <= 4'b0000;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_op    <= bus.instruction[15:12];
                    r_ext   <= bus.instruction[7:4];
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    case (w_class)
                        ALU_R, ALU_I: r_state <= S_EXEC;
                        SHIFT:        r_state <= S_SHIFT;
                        LOAD:         r_state <= S_MEMRD;
                        STOR:         r_state <= S_MEMWR;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_EXEC:  r_state <= w_is_cmp ? S_FETCH : S_WB;
                S_SHIFT: r_state <= S_WB;
                S_MEMRD: r_state <= S_LDWB;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // NOTE: reset gates the decode so outputs drop the instant reset asserts,
    // even though FETCH (the reset state) normally drives memRead/pcRegEn.
    always_comb begin
        w_ctrl = '0;
        if (reset) begin
            if (r_state != S_FETCH) begin
                w_ctrl.alu_control = w_alu_control;
            end
            case (r_state)
                S_FETCH: begin
                    w_ctrl.mem_read  = 1'b1;
                    w_ctrl.pc_reg_en = 1'b1;
                end
                S_DECODE: begin
                    w_ctrl.src_reg_en = 1'b1;
                    w_ctrl.dst_reg_en = 1'b1;
                    w_ctrl.imm_reg_en = 1'b1;
                    w_ctrl.ir_s       = w_is_imm;
                    w_ctrl.sign_en    = w_is_imm;
                    w_ctrl.illegal    = (w_class == ILLEGAL);
                    w_ctrl.inst_done  = (w_class == ILLEGAL);
                end
                S_EXEC: begin
                    w_ctrl.result_reg_en = 1'b1;
                    w_ctrl.mux4_en       = (w_class == ALU_I) ? MUX4_SIGN : MUX4_SRC;
                    w_ctrl.inst_done     = w_is_cmp;
                end
                S_SHIFT: begin
                    w_ctrl.result_reg_en    = 1'b1;
                    w_ctrl.shift_alu_mux_en = 1'b1;
                    w_ctrl.reg_imm_mux_en   = w_is_imm;
                end
                S_WB: begin
                    w_ctrl.reg_file_en = 1'b1;
                    w_ctrl.inst_done   = 1'b1;
                end
                S_MEMRD: begin
                    w_ctrl.mem_read   = 1'b1;
                    w_ctrl.regpc_cont = REGPC_SRC;
                end
                S_LDWB: begin
                    w_ctrl.reg_file_en      = 1'b1;
                    w_ctrl.ex_mem_result_en = 1'b1;
                    w_ctrl.inst_done        = 1'b1;
                end
                S_MEMWR: begin
                    w_ctrl.mem_write  = 1'b1;
                    w_ctrl.regpc_cont = REGPC_SRC;
                    w_ctrl.inst_done  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.aluControl    = w_ctrl.alu_control;
    assign bus.pcRegEn       = w_ctrl.pc_reg_en;
    assign bus.srcRegEn      = w_ctrl.src_reg_en;
    assign bus.dstRegEn      = w_ctrl.dst_reg_en;
    assign bus.immRegEn      = w_ctrl.imm_reg_en;
    assign bus.resultRegEn   = w_ctrl.result_reg_en;
    assign bus.signEn        = w_ctrl.sign_en;
    assign bus.regFileEn     = w_ctrl.reg_file_en;
    assign bus.pcRegMuxEn    = w_ctrl.pc_reg_mux_en;
    assign bus.shiftALUMuxEn = w_ctrl.shift_alu_mux_en;
    assign bus.regImmMuxEn   = w_ctrl.reg_imm_mux_en;
    assign bus.exMemResultEn = w_ctrl.ex_mem_result_en;
    assign bus.irS           = w_ctrl.ir_s;
    assign bus.mux4En        = w_ctrl.mux4_en;
    assign bus.regpcCont     = w_ctrl.regpc_cont;
    assign bus.memRead       = w_ctrl.mem_read;
    assign bus.memWrite      = w_ctrl.mem_write;
    assign bus.instDone      = w_ctrl.inst_done;
    assign bus.illegal       = w_ctrl.illegal;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: each issued instruction queues its
// hand-derived per-cycle control vectors; a negedge monitor pops and compares.
module tb_control_fsm;

    localparam logic [15:0] F_PC    = 16'h0001;
    localparam logic [15:0] F_SRC   = 16'h0002;
    localparam logic [15:0] F_DST   = 16'h0004;
    localparam logic [15:0] F_IMM   = 16'h0008;
    localparam logic [15:0] F_RES   = 16'h0010;
    localparam logic [15:0] F_SIGN  = 16'h0020;
    localparam logic [15:0] F_RF    = 16'h0040;
    localparam logic [15:0] F_PCMUX = 16'h0080;
    localparam logic [15:0] F_SHMUX = 16'h0100;
    localparam logic [15:0] F_RIMUX = 16'h0200;
    localparam logic [15:0] F_EXMEM = 16'h0400;
    localparam logic [15:0] F_IRS   = 16'h0800;
    localparam logic [15:0] F_MRD   = 16'h1000;
    localparam logic [15:0] F_MWR   = 16'h2000;
    localparam logic [15:0] F_DONE  = 16'h4000;
    localparam logic [15:0] F_ILL   = 16'h8000;

    localparam logic [15:0] FE  = F_MRD | F_PC;
    localparam logic [15:0] D_R = F_SRC | F_DST | F_IMM;
    localparam logic [15:0] D_I = D_R | F_IRS | F_SIGN;
    localparam logic [15:0] WBF = F_RF | F_DONE;

    // {instruction, expected aluControl, immediate form}
    localparam logic [15:0] ALU_INSTR [10] = '{16'h0391, 16'h0212, 16'h0223, 16'h0234, 16'h02D4,
                                               16'h1201, 16'h2201, 16'h3201, 16'h9201, 16'hD2FF};
    localparam logic [3:0]  ALU_EXP   [10] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6,
                                               4'h2, 4'h3, 4'h4, 4'h1, 4'h6};
    localparam logic        ALU_ISI   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [15:0] ILL_INSTR [6]  = '{16'h7000, 16'h0300, 16'h0370,
                                               16'h4120, 16'h8360, 16'hF000};

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    string       name_q[$];
    logic [23:0] w_act;

    control_fsm_if bus();

    control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign w_act = {bus.aluControl, bus.mux4En, bus.regpcCont,
                    bus.illegal, bus.instDone, bus.memWrite, bus.memRead,
                    bus.irS, bus.exMemResultEn, bus.regImmMuxEn, bus.shiftALUMuxEn,
                    bus.pcRegMuxEn, bus.regFileEn, bus.signEn, bus.resultRegEn,
                    bus.immRegEn, bus.dstRegEn, bus.srcRegEn, bus.pcRegEn};

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got alu=%b mux4=%b regpc=%b flags=%h, expected alu=%b mux4=%b regpc=%b flags=%h",
                     nm, act[23:20], act[19:18], act[17:16], act[15:0],
                     req[23:20], req[19:18], req[17:16], req[15:0]);
        end
    endtask

    task automatic expect_cyc(input string nm, input logic [3:0] alu, input logic [1:0] mux4,
                              input logic [1:0] regpc, input logic [15:0] flags);
        name_q.push_back(nm);
        exp_q.push_back({alu, mux4, regpc, flags});
    endtask

    // Called #1 after the edge that entered FETCH; the word is only valid for that cycle.
    task automatic run(input logic [15:0] instr, input int ncyc);
        bus.instruction = instr;
        @(posedge clk);
        #1;
        bus.instruction = ~instr;
        repeat (ncyc - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_alu(input string nm, input logic [15:0] instr, input logic [3:0] alu,
                           input logic is_i, input logic is_cmp);
        expect_cyc({nm, ".fetch"}, 4'h0, 2'b00, 2'b00, FE);
        expect_cyc({nm, ".decode"}, alu, 2'b00, 2'b00, is_i ? D_I : D_R);
        expect_cyc({nm, ".exec"}, alu, is_i ? 2'b01 : 2'b00, 2'b00,
                   is_cmp ? (F_RES | F_DONE) : F_RES);
        if (!is_cmp) expect_cyc({nm, ".wb"}, alu, 2'b00, 2'b00, WBF);
        run(instr, is_cmp ? 3 : 4);
    endtask

    task automatic run_shift(input string nm, input logic [15:0] instr, input logic is_i);
        expect_cyc({nm, ".fetch"}, 4'h0, 2'b00, 2'b00, FE);
        expect_cyc({nm, ".decode"}, 4'h0, 2'b00, 2'b00, is_i ? D_I : D_R);
        expect_cyc({nm, ".shift"}, 4'h0, 2'b00, 2'b00,
                   is_i ? (F_RES | F_SHMUX | F_RIMUX) : (F_RES | F_SHMUX));
        expect_cyc({nm, ".wb"}, 4'h0, 2'b00, 2'b00, WBF);
        run(instr, 4);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check(name_q.pop_front(), w_act, exp_q.pop_front());
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.instruction = 16'h0000;
        expect_cyc("reset.hold", 4'h0, 2'b00, 2'b00, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_alu("add", 16'h0355, 4'h0, 1'b0, 1'b0);
        run_alu("addi", 16'h527F, 4'h0, 1'b1, 1'b0);
        run_alu("cmp", 16'h01B2, 4'h5, 1'b0, 1'b1);

        expect_cyc("load.fetch", 4'h0, 2'b00, 2'b00, FE);
        expect_cyc("load.decode", 4'h0, 2'b00, 2'b00, D_R);
        expect_cyc("load.memrd", 4'h0, 2'b00, 2'b00, F_MRD);
        expect_cyc("load.ldwb", 4'h0, 2'b00, 2'b00, F_RF | F_EXMEM | F_DONE);
        run(16'h4104, 4);

        expect_cyc("stor.fetch", 4'h0, 2'b00, 2'b00, FE);
        expect_cyc("stor.decode", 4'h0, 2'b00, 2'b00, D_R);
        expect_cyc("stor.memwr", 4'h0, 2'b00, 2'b00, F_MWR | F_DONE);
        run(16'h4647, 3);

        run_shift("lshi", 16'h8302, 1'b1);
        run_shift("lsh", 16'h8341, 1'b0);
        run_shift("lshi_ext1", 16'h8315, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_alu($sformatf("alu%0d", i), ALU_INSTR[i], ALU_EXP[i], ALU_ISI[i], 1'b0);
        end
        run_alu("cmpi", 16'hB105, 4'h5, 1'b1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            expect_cyc($sformatf("ill%0d.fetch", i), 4'h0, 2'b00, 2'b00, FE);
            expect_cyc($sformatf("ill%0d.decode", i), 4'h0, 2'b00, 2'b00, D_R | F_ILL | F_DONE);
            run(ILL_INSTR[i], 2);
        end

        // ADD interrupted by reset during EXEC
        expect_cyc("rst.fetch", 4'h0, 2'b00, 2'b00, FE);
        expect_cyc("rst.decode", 4'h0, 2'b00, 2'b00, D_R);
        expect_cyc("rst.exec", 4'h0, 2'b00, 2'b00, F_RES);
        run(16'h0355, 2);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst.immediate", w_act, 24'h000000);
        expect_cyc("rst.held", 4'h0, 2'b00, 2'b00, 16'h0000);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_alu("post_rst.cmp", 16'h01B2, 4'h5, 1'b0, 1'b1);
        run_alu("post_rst.xori", 16'h3A5C, 4'h4, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
